// File: rtl/frequency_analysis_pkg.sv
// Shared types and window arithmetic for the sample period classifier.
//   state_e      : measurement FSM states
//   class_e      : period classification result
//   window_bound : lower/upper period bound (in clock cycles) for a carrier
package frequency_analysis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        F0      = 2'd0,
        F1      = 2'd1,
        UNKNOWN = 2'd2
    } class_e;

    // Highest carrier frequency gives the shortest period, hence the lower bound.
    function automatic int unsigned window_bound(
        input int unsigned clock_hz,
        input int unsigned freq_hz,
        input int unsigned dev_hz,
        input logic        upper
    );
        if (upper) begin
            return clock_hz / (freq_hz - dev_hz);
        end
        return clock_hz / (freq_hz + dev_hz);
    endfunction

endpackage

// File: rtl/sample_edge_detector.sv
// Synchronizes an asynchronous 1-bit sample and flags its rising edges.
//   clk    : destination clock
//   rst_n  : async active-low reset, all flops to 0
//   din    : asynchronous sample input
//   rise_c : combinational pulse, high for one cycle after a synchronized 0->1
module sample_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q,   dly_d;

    // Two-stage synchronizer followed by a delayed copy for edge detection.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign rise_c = sync2_q & ~dly_q;

endmodule

// File: rtl/sample_period_classifier.sv
// Measures the period between rising edges of a point-sample stream, classifies
// each period as carrier F0, carrier F1 or unknown, and accumulates the cycles
// per class with saturation.
//   clock, resetn : system clock, async active-low reset
//   sample_data   : asynchronous point sample
//   enable        : measurement window (level)
//   clear_n       : synchronous active-low clear of accumulators and state
//   f0_value      : accumulated cycles classified F0
//   f1_value      : accumulated cycles classified F1
//   unknown       : accumulated unclassified cycles, including timeouts
//   last_period   : most recent measured period
//   period_valid  : one-cycle pulse on any accumulator update
module sample_period_classifier
    import frequency_analysis_pkg::*;
#(
    parameter int unsigned FREQUENCY0           = 5000,
    parameter int unsigned FREQUENCY1           = 10000,
    parameter int unsigned FREQUENCY0_DEVIATION = 30,
    parameter int unsigned FREQUENCY1_DEVIATION = 30,
    parameter int unsigned CLOCK_FREQUENCY      = 100000000,
    parameter int unsigned COUNTER_WIDTH        = 32
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     sample_data,
    input  logic                     enable,
    input  logic                     clear_n,
    output logic [COUNTER_WIDTH-1:0] f0_value,
    output logic [COUNTER_WIDTH-1:0] f1_value,
    output logic [COUNTER_WIDTH-1:0] unknown,
    output logic [COUNTER_WIDTH-1:0] last_period,
    output logic                     period_valid
);

    localparam int unsigned CW  = COUNTER_WIDTH;
    localparam int unsigned LO0 = window_bound(CLOCK_FREQUENCY, FREQUENCY0, FREQUENCY0_DEVIATION, 1'b0);
    localparam int unsigned HI0 = window_bound(CLOCK_FREQUENCY, FREQUENCY0, FREQUENCY0_DEVIATION, 1'b1);
    localparam int unsigned LO1 = window_bound(CLOCK_FREQUENCY, FREQUENCY1, FREQUENCY1_DEVIATION, 1'b0);
    localparam int unsigned HI1 = window_bound(CLOCK_FREQUENCY, FREQUENCY1, FREQUENCY1_DEVIATION, 1'b1);
    localparam int unsigned TIMEOUT = 2 * ((HI0 > HI1) ? HI0 : HI1);

    localparam logic [CW-1:0] LO0_W     = CW'(LO0);
    localparam logic [CW-1:0] HI0_W     = CW'(HI0);
    localparam logic [CW-1:0] LO1_W     = CW'(LO1);
    localparam logic [CW-1:0] HI1_W     = CW'(HI1);
    localparam logic [CW-1:0] TIMEOUT_W = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] f0_q, f0_d;
    logic [CW-1:0] f1_q, f1_d;
    logic [CW-1:0] unknown_q, unknown_d;
    logic [CW-1:0] last_q, last_d;
    logic          valid_q, valid_d;

    logic          rise_c;
    logic [CW-1:0] period_c;
    class_e        class_c;

    sample_edge_detector u_edge (
        .clk    (clock),
        .rst_n  (resetn),
        .din    (sample_data),
        .rise_c (rise_c)
    );

    // Accumulators stick at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_add(
        input logic [CW-1:0] a,
        input logic [CW-1:0] b
    );
        logic [CW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
    endfunction

    // Period ending on this cycle's edge and its class; F0 wins on overlap.
    always_comb begin
        period_c = count_q + CW'(1);
        if (period_c >= LO0_W && period_c <= HI0_W) begin
            class_c = F0;
        end else if (period_c >= LO1_W && period_c <= HI1_W) begin
            class_c = F1;
        end else begin
            class_c = UNKNOWN;
        end
    end

    // Next-state and datapath updates; clear beats enable, which beats edges.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        f0_d      = f0_q;
        f1_d      = f1_q;
        unknown_d = unknown_q;
        last_d    = last_q;
        valid_d   = 1'b0;

        if (!clear_n) begin
            state_d   = enable ? ARM : IDLE;
            count_d   = '0;
            f0_d      = '0;
            f1_d      = '0;
            unknown_d = '0;
            last_d    = '0;
        end else if (!enable) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    count_d = '0;
                end
                ARM: begin
                    count_d = '0;
                    if (rise_c) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_c) begin
                        last_d  = period_c;
                        valid_d = 1'b1;
                        count_d = '0;
                        case (class_c)
                            F0:      f0_d      = sat_add(f0_q, period_c);
                            F1:      f1_d      = sat_add(f1_q, period_c);
                            default: unknown_d = sat_add(unknown_q, period_c);
                        endcase
                    end else if (period_c == TIMEOUT_W) begin
                        // Stream stalled: book the whole timeout as unknown and re-arm.
                        unknown_d = sat_add(unknown_q, TIMEOUT_W);
                        valid_d   = 1'b1;
                        count_d   = '0;
                        state_d   = ARM;
                    end else begin
                        count_d = period_c;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            f0_q      <= '0;
            f1_q      <= '0;
            unknown_q <= '0;
            last_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            f0_q      <= f0_d;
            f1_q      <= f1_d;
            unknown_q <= unknown_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

    assign f0_value     = f0_q;
    assign f1_value     = f1_q;
    assign unknown      = unknown_q;
    assign last_period  = last_q;
    assign period_valid = valid_q;

endmodule

// File: tb/tb_sample_period_classifier.sv
// Directed bench for sample_period_classifier. Runs with a 10 MHz clock rate so
// every window is a tenth of the default: LO0=1988 HI0=2012 LO1=997 HI1=1003
// TIMEOUT=4024. A second instance with 12-bit counters shares the stimulus and
// shows accumulator saturation at 4095.
module tb_sample_period_classifier;

    localparam int unsigned CLK_HZ   = 10000000;
    localparam int unsigned SAT_MAX  = 4095;
    localparam int unsigned TIMEOUT  = 4024;
    localparam int unsigned NV       = 16;

    logic        clock = 1'b0;
    logic        resetn;
    logic        sample_data;
    logic        enable;
    logic        clear_n;
    logic [31:0] f0_value, f1_value, unknown, last_period;
    logic        period_valid;
    logic [11:0] s_f0, s_f1, s_unk, s_last;
    logic        s_pv;

    int n_tests = 0;
    int n_fail  = 0;
    int pv_cnt  = 0;

    typedef struct {
        int unsigned period;
        int unsigned cls;     // 0 = F0, 1 = F1, 2 = unknown
    } vec_t;

    vec_t vecs [NV];

    sample_period_classifier #(
        .CLOCK_FREQUENCY (CLK_HZ)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .sample_data  (sample_data),
        .enable       (enable),
        .clear_n      (clear_n),
        .f0_value     (f0_value),
        .f1_value     (f1_value),
        .unknown      (unknown),
        .last_period  (last_period),
        .period_valid (period_valid)
    );

    sample_period_classifier #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .COUNTER_WIDTH   (12)
    ) dut_sat (
        .clock        (clock),
        .resetn       (resetn),
        .sample_data  (sample_data),
        .enable       (enable),
        .clear_n      (clear_n),
        .f0_value     (s_f0),
        .f1_value     (s_f1),
        .unknown      (s_unk),
        .last_period  (s_last),
        .period_valid (s_pv)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (period_valid) pv_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat12(input longint v);
        return (v > SAT_MAX) ? longint'(SAT_MAX) : v;
    endfunction

    // Rising edge now, then the rest of a period of n cycles ending just before the next edge.
    // Caller has already spent 4 cycles after the previous edge.
    task automatic finish_period(input int n);
        tick(n / 2 - 4);
        sample_data = 1'b0;
        tick(n - n / 2);
        sample_data = 1'b1;
    endtask

    longint exp_f0, exp_f1, exp_unk;
    int     base_pv;

    initial begin
        vecs[0]  = '{2000, 0};
        vecs[1]  = '{2000, 0};
        vecs[2]  = '{2000, 0};
        vecs[3]  = '{2000, 0};
        vecs[4]  = '{1000, 1};
        vecs[5]  = '{1000, 1};
        vecs[6]  = '{1000, 1};
        vecs[7]  = '{1500, 2};
        vecs[8]  = '{1500, 2};
        vecs[9]  = '{997,  1};
        vecs[10] = '{996,  2};
        vecs[11] = '{1003, 1};
        vecs[12] = '{1004, 2};
        vecs[13] = '{1988, 0};
        vecs[14] = '{1987, 2};
        vecs[15] = '{2013, 2};

        resetn      = 1'b0;
        enable      = 1'b0;
        clear_n     = 1'b1;
        sample_data = 1'b0;

        // Reset, then idle with the input toggling.
        for (int i = 0; i < 4; i++) begin
            sample_data = ~sample_data;
            tick(1);
        end
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sample_data = ~sample_data;
            tick(1);
        end
        check("idle_f0", f0_value, 0);
        check("idle_f1", f1_value, 0);
        check("idle_unk", unknown, 0);
        check("idle_last", last_period, 0);
        check("idle_pv_count", pv_cnt, 0);

        // Arm, then a priming edge that must not produce a pulse.
        sample_data = 1'b0;
        enable      = 1'b1;
        tick(5);
        base_pv = pv_cnt;
        sample_data = 1'b1;
        tick(3);
        check("arm_edge_pv", period_valid, 0);
        tick(1);

        exp_f0 = 0; exp_f1 = 0; exp_unk = 0;
        for (int i = 0; i < NV; i++) begin
            int unsigned p;
            p = vecs[i].period;
            finish_period(int'(p));
            tick(3);
            case (vecs[i].cls)
                0:       exp_f0  += p;
                1:       exp_f1  += p;
                default: exp_unk += p;
            endcase
            check($sformatf("v%0d_pv", i), period_valid, 1);
            check($sformatf("v%0d_last", i), last_period, p);
            check($sformatf("v%0d_f0", i), f0_value, exp_f0);
            check($sformatf("v%0d_f1", i), f1_value, exp_f1);
            check($sformatf("v%0d_unk", i), unknown, exp_unk);
            check($sformatf("v%0d_sat_f0", i), s_f0, sat12(exp_f0));
            check($sformatf("v%0d_sat_f1", i), s_f1, sat12(exp_f1));
            check($sformatf("v%0d_sat_unk", i), s_unk, sat12(exp_unk));
            check($sformatf("v%0d_sat_pv", i), s_pv, 1);
            tick(1);
            check($sformatf("v%0d_pv_single", i), period_valid, 0);
            if (i == 3) begin
                check("f0_run_f0", f0_value, 80 * 100);
                check("f0_run_pulses", pv_cnt - base_pv, 4);
            end
        end
        check("table_pulses", pv_cnt - base_pv, NV);

        // Timeout: input stuck low long past the timeout.
        base_pv = pv_cnt;
        sample_data = 1'b0;
        tick(5000);
        exp_unk += TIMEOUT;
        check("timeout_unk", unknown, exp_unk);
        check("timeout_pulses", pv_cnt - base_pv, 1);
        sample_data = 1'b1;
        tick(3);
        check("timeout_rearm_pv", period_valid, 0);
        tick(1);
        check("timeout_rearm_unk", unknown, exp_unk);
        finish_period(1000);
        tick(3);
        exp_f1 += 1000;
        check("after_timeout_f1", f1_value, exp_f1);
        check("after_timeout_pv", period_valid, 1);
        tick(1);

        // Clear coincident with the cycle the edge is registered.
        base_pv = pv_cnt;
        finish_period(1000);
        tick(2);
        clear_n = 1'b0;
        tick(1);
        clear_n = 1'b1;
        check("clear_pv", period_valid, 0);
        check("clear_f0", f0_value, 0);
        check("clear_f1", f1_value, 0);
        check("clear_unk", unknown, 0);
        check("clear_last", last_period, 0);
        tick(5);
        check("clear_pulses", pv_cnt - base_pv, 0);
        finish_period(1000);
        tick(4);
        check("clear_rearm_pulses", pv_cnt - base_pv, 0);
        finish_period(1000);
        tick(3);
        check("after_clear_f1", f1_value, 1000);
        check("after_clear_pv", period_valid, 1);
        tick(1);

        // Enable dropped mid-period; values hold while the input keeps toggling.
        tick(496);
        enable  = 1'b0;
        base_pv = pv_cnt;
        for (int i = 0; i < 12; i++) begin
            sample_data = 1'b0;
            tick(50);
            sample_data = 1'b1;
            tick(50);
        end
        check("disable_f0", f0_value, 0);
        check("disable_f1", f1_value, 1000);
        check("disable_unk", unknown, 0);
        check("disable_last", last_period, 1000);
        check("disable_pulses", pv_cnt - base_pv, 0);
        sample_data = 1'b0;
        tick(10);
        enable = 1'b1;
        tick(5);
        sample_data = 1'b1;
        tick(4);
        check("reenable_arm_pulses", pv_cnt - base_pv, 0);
        finish_period(1000);
        tick(3);
        check("reenable_f1", f1_value, 2000);
        check("reenable_last", last_period, 1000);
        tick(1);

        // Asynchronous reset mid-period.
        tick(200);
        resetn = 1'b0;
        #1;
        check("areset_f1", f1_value, 0);
        check("areset_last", last_period, 0);
        sample_data = 1'b0;
        tick(5);
        resetn  = 1'b1;
        base_pv = pv_cnt;
        tick(5);
        sample_data = 1'b1;
        tick(4);
        check("areset_first_edge_pulses", pv_cnt - base_pv, 0);
        finish_period(1000);
        tick(3);
        check("areset_then_f1", f1_value, 1000);
        check("areset_then_pv", period_valid, 1);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_period_classifier.md
# sample_period_classifier

Measures the period of each 1-bit point-sample stream produced by the pixel point sampler, in system-clock cycles. It classifies every complete period as carrier frequency F0, carrier frequency F1 or unknown, and accumulates per-class action time. One instance per monitored point sits directly downstream of the sampler. Its three accumulators are read back by the register-writeback logic after `stop`.

## Interface
- `FREQUENCY0`, 5000: first carrier, Hz.
- `FREQUENCY1`, 10000: second carrier, Hz.
- `FREQUENCY0_DEVIATION`, 30: tolerance on F0, Hz.
- `FREQUENCY1_DEVIATION`, 30: tolerance on F1, Hz.
- `CLOCK_FREQUENCY`, 100000000: `clock` rate, Hz.
- `COUNTER_WIDTH`, 32: width of the accumulators and the period counter.
- `clock`  in  1  system clock (AXI clock domain).
- `resetn`  in  1  reset; asynchronous assert, active-low.
- `sample_data`  in  1  point sample from the pixel-clock domain; asynchronous to `clock`.
- `enable`  in  1  measurement window, level.
- `clear_n`  in  1  synchronous active-low clear of accumulators and state.
- `f0_value`  out  COUNTER_WIDTH  accumulated cycles classified F0.
- `f1_value`  out  COUNTER_WIDTH  accumulated cycles classified F1.
- `unknown`  out  COUNTER_WIDTH  accumulated cycles not classified, including timeouts.
- `last_period`  out  COUNTER_WIDTH  most recent measured period.
- `period_valid`  out  1  one-cycle pulse when any accumulator updates.

## Operation
- Window constants are integer-divided localparams: `LO0=CLOCK_FREQUENCY/(FREQUENCY0+FREQUENCY0_DEVIATION)`, `HI0=CLOCK_FREQUENCY/(FREQUENCY0-FREQUENCY0_DEVIATION)`. `LO1` and `HI1` are defined likewise.
- `TIMEOUT = 2*max(HI0,HI1)`.
- `sample_data` passes through a 2-FF synchronizer. A rising edge is `sync & ~sync_d`.
- State machine:
  - IDLE: `enable=0`. Counter held at 0; accumulators hold. IDLE→ARM when `enable=1`.
  - ARM: waits for the first rising edge. On the edge: counter←0, ARM→MEASURE. Nothing is accumulated.
  - MEASURE: counter increments every cycle. On a rising edge:
    - P = counter+1; `last_period`←P.
    - Class F0 if LO0≤P≤HI0; else F1 if LO1≤P≤HI1; else unknown.
    - The matching accumulator += P; `period_valid`=1; counter←0; stay in MEASURE.
  - Timeout: if counter+1 reaches TIMEOUT with no edge, `unknown` += TIMEOUT, `period_valid`=1, MEASURE→ARM.
- Window overlap: F0 takes priority.
- Accumulators saturate at 2^COUNTER_WIDTH−1 and never wrap.
- `enable` falling in ARM or MEASURE: go to IDLE and discard the partial period. Accumulators hold, so they are readable after stop.
- `clear_n=0`:
  - Accumulators, `last_period` and counter←0; no `period_valid`.
  - State←ARM if `enable`, else IDLE.
  - Clear wins over a simultaneous edge or timeout; that event is discarded.
- `enable=0` coincident with an edge: the edge is ignored.
- Reset values: all outputs 0, state IDLE, synchronizer flops 0.

## Timing
- Latency: the clock edge that first samples `sample_data` high is edge 1. `sync` is high after edge 2. The edge is detected combinationally and registered at edge 3. Accumulator, `last_period` and `period_valid` are visible after edge 3.
- A square wave of period N cycles yields P=N exactly, since synchronizer delay is constant.
- `period_valid` is high exactly one cycle per update, with no back-to-back requirement. The minimum period that can be measured is 2 cycles.
- `resetn` assertion mid-period clears asynchronously. The first edge after release only arms.
- Outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `frequency_analysis_pkg`:
  - state enum (IDLE, ARM, MEASURE);
  - class enum (F0, F1, UNKNOWN);
  - a constant function computing the window bounds, so that readback and software-facing code share the formula.
- Sub-module `sample_edge_detector`: 2-FF synchronizer, delayed copy, rising-edge pulse output. It has its own async active-low reset.
- Top level holds the FSM, the period counter, the classifier compare and the saturating adders.

## Test plan
All scenarios use defaults: LO0=19880, HI0=20120, LO1=9970, HI1=10030, TIMEOUT=40240.
- Reset and idle: `resetn` low, then release with `enable=0` and `sample_data` toggling → all outputs 0, no `period_valid`.
- F0: `enable=1`, square wave of period 20000 cycles, 5 rising edges → `f0_value`=80000, `f1_value`=0, `unknown`=0, `last_period`=20000, 4 `period_valid` pulses.
- F1 then unknown: 3 periods of 10000, then 2 periods of 15000 → `f1_value`=30000, `unknown`=30000. Boundaries: P=9970 classifies F1; P=9969 classifies unknown.
- Timeout: arm, then hold `sample_data` low for 50000 cycles → `unknown`=40240 at counter+1=40240; the next edge only arms (no pulse).
- Clear and enable edge cases:
  - `clear_n` low in the same cycle as a detected edge → all accumulators 0, no pulse.
  - `enable` dropped 5000 cycles into a period → values unchanged and held for ≥1000 cycles.
- Saturation: preload via 2^32−1 stimulus (force) with `f0_value`=2^32−100, then one P=20000 → `f0_value`=2^32−1.
